// File: rtl/ysyx_23060236_arbiter_if.sv
// AXI4-Lite style bus bundle (ar/r/aw/w/b) shared by the IFU, LSU and memory sides of the arbiter.
interface ysyx_23060236_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arsize, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awsize, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arsize, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awsize, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/ysyx_23060236_arbiter.sv
// Single-outstanding arbiter merging IFU reads and LSU reads/writes onto one memory bus.
// LSU has fixed priority (read before write); every grant is preceded by one IDLE cycle.
module ysyx_23060236_arbiter #(
  parameter logic [2:0] IFU_ARSIZE = 3'b010
) (
  input  logic                          clock,
  input  logic                          reset,
  ysyx_23060236_arbiter_if.slave        ifu_bus,
  ysyx_23060236_arbiter_if.slave        lsu_bus,
  ysyx_23060236_arbiter_if.master       mem_bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } state_e;

  state_e state_q;
  state_e state_d;

  // The IFU only ever reads; its write-side and size inputs are not consumed.
  logic unused_ifu;
  assign unused_ifu = ^{ifu_bus.arsize, ifu_bus.awaddr, ifu_bus.awsize, ifu_bus.awvalid,
                        ifu_bus.wdata, ifu_bus.wstrb, ifu_bus.wvalid, ifu_bus.bready};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;

    ifu_bus.arready = 1'b0;
    ifu_bus.rdata   = '0;
    ifu_bus.rresp   = '0;
    ifu_bus.rvalid  = 1'b0;
    ifu_bus.awready = 1'b0;
    ifu_bus.wready  = 1'b0;
    ifu_bus.bresp   = '0;
    ifu_bus.bvalid  = 1'b0;

    lsu_bus.arready = 1'b0;
    lsu_bus.rdata   = '0;
    lsu_bus.rresp   = '0;
    lsu_bus.rvalid  = 1'b0;
    lsu_bus.awready = 1'b0;
    lsu_bus.wready  = 1'b0;
    lsu_bus.bresp   = '0;
    lsu_bus.bvalid  = 1'b0;

    mem_bus.araddr  = '0;
    mem_bus.arsize  = '0;
    mem_bus.arvalid = 1'b0;
    mem_bus.rready  = 1'b0;
    mem_bus.awaddr  = '0;
    mem_bus.awsize  = '0;
    mem_bus.awvalid = 1'b0;
    mem_bus.wdata   = '0;
    mem_bus.wstrb   = '0;
    mem_bus.wvalid  = 1'b0;
    mem_bus.bready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (lsu_bus.arvalid)                       state_d = LSU_RD;
        else if (lsu_bus.awvalid || lsu_bus.wvalid) state_d = LSU_WR;
        else if (ifu_bus.arvalid)                  state_d = IFU_RD;
      end

      IFU_RD: begin
        mem_bus.araddr  = ifu_bus.araddr;
        mem_bus.arsize  = IFU_ARSIZE;
        mem_bus.arvalid = ifu_bus.arvalid;
        ifu_bus.arready = mem_bus.arready;
        ifu_bus.rdata   = mem_bus.rdata;
        ifu_bus.rresp   = mem_bus.rresp;
        ifu_bus.rvalid  = mem_bus.rvalid;
        mem_bus.rready  = ifu_bus.rready;
        if (mem_bus.rvalid && ifu_bus.rready) state_d = IDLE;
      end

      LSU_RD: begin
        mem_bus.araddr  = lsu_bus.araddr;
        mem_bus.arsize  = lsu_bus.arsize;
        mem_bus.arvalid = lsu_bus.arvalid;
        lsu_bus.arready = mem_bus.arready;
        lsu_bus.rdata   = mem_bus.rdata;
        lsu_bus.rresp   = mem_bus.rresp;
        lsu_bus.rvalid  = mem_bus.rvalid;
        mem_bus.rready  = lsu_bus.rready;
        if (mem_bus.rvalid && lsu_bus.rready) state_d = IDLE;
      end

      LSU_WR: begin
        // aw and w travel independently; only the b handshake ends the write.
        mem_bus.awaddr  = lsu_bus.awaddr;
        mem_bus.awsize  = lsu_bus.awsize;
        mem_bus.awvalid = lsu_bus.awvalid;
        lsu_bus.awready = mem_bus.awready;
        mem_bus.wdata   = lsu_bus.wdata;
        mem_bus.wstrb   = lsu_bus.wstrb;
        mem_bus.wvalid  = lsu_bus.wvalid;
        lsu_bus.wready  = mem_bus.wready;
        lsu_bus.bresp   = mem_bus.bresp;
        lsu_bus.bvalid  = mem_bus.bvalid;
        mem_bus.bready  = lsu_bus.bready;
        if (mem_bus.bvalid && lsu_bus.bready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060236_arbiter.sv
// Bench for ysyx_23060236_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (priority order list and a byte-merged memory map).
module tb_ysyx_23060236_arbiter;
  localparam int NUM_BUNDLES = 40;
  localparam int BUNDLE_BUDGET = 200;

  logic clock;
  logic reset;

  ysyx_23060236_arbiter_if ifu_bus();
  ysyx_23060236_arbiter_if lsu_bus();
  ysyx_23060236_arbiter_if m_bus();

  ysyx_23060236_arbiter #(.IFU_ARSIZE(3'b010)) dut (
    .clock   (clock),
    .reset   (reset),
    .ifu_bus (ifu_bus),
    .lsu_bus (lsu_bus),
    .mem_bus (m_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass;
  int n_total;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clear_inputs();
    ifu_bus.araddr = '0; ifu_bus.arsize = '0; ifu_bus.arvalid = 0; ifu_bus.rready = 0;
    ifu_bus.awaddr = '0; ifu_bus.awsize = '0; ifu_bus.awvalid = 0;
    ifu_bus.wdata = '0; ifu_bus.wstrb = '0; ifu_bus.wvalid = 0; ifu_bus.bready = 0;
    lsu_bus.araddr = '0; lsu_bus.arsize = '0; lsu_bus.arvalid = 0; lsu_bus.rready = 0;
    lsu_bus.awaddr = '0; lsu_bus.awsize = '0; lsu_bus.awvalid = 0;
    lsu_bus.wdata = '0; lsu_bus.wstrb = '0; lsu_bus.wvalid = 0; lsu_bus.bready = 0;
    m_bus.arready = 0; m_bus.rdata = '0; m_bus.rresp = '0; m_bus.rvalid = 0;
    m_bus.awready = 0; m_bus.wready = 0; m_bus.bresp = '0; m_bus.bvalid = 0;
  endtask

  // Memory contents as seen by the reference model and by the bench's slave.
  logic [31:0] exp_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  function automatic logic [31:0] seed_val(input logic [31:0] a);
    return a ^ 32'h5a5a_a5a5;
  endfunction

  function automatic logic [31:0] rd_exp(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : seed_val(a);
  endfunction

  function automatic logic [31:0] rd_slv(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : seed_val(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (s[b]) res[8*b +: 8] = d[8*b +: 8];
    return res;
  endfunction

  // Random-phase state: requesters (0=IFU read, 1=LSU read, 2=LSU write) and slave.
  int          exp_q[$];
  int          got_q[$];
  bit          ifu_p, lrd_p, lwr_p, done, timed_out;
  logic [31:0] ifu_a, lrd_a, lwr_a, lwr_d;
  logic [2:0]  lrd_s;
  logic [3:0]  lwr_s;
  bit          s_rbusy, s_rv, s_awg, s_wg, s_bv;
  logic [31:0] s_ra, s_wa, s_wd;
  logic [3:0]  s_ws;
  logic [1:0]  s_bresp;
  int          s_rdly;
  bit          h_ar, h_iar, h_lar, h_r, h_ir, h_lr, h_aw, h_law, h_w, h_lw, h_b, h_lb;
  logic [31:0] h_araddr, h_awaddr, h_wdata;
  logic [3:0]  h_wstrb;
  int          bundles, bcyc;
  int unsigned pick;

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    clear_inputs();

    // Reset holds IDLE regardless of requests or stray responses.
    lsu_bus.arvalid = 1; ifu_bus.arvalid = 1; m_bus.rvalid = 1;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_arvalid", m_bus.arvalid, 0);
    chk("rst_rready", m_bus.rready, 0);
    chk("rst_awvalid", m_bus.awvalid, 0);
    chk("rst_lsu_arready", lsu_bus.arready, 0);
    @(negedge clock); clear_inputs(); reset = 1'b0;
    #1 chk("idle_arvalid", m_bus.arvalid, 0);

    // IFU only, arready after two wait cycles.
    @(negedge clock); ifu_bus.araddr = 32'h3000_0000; ifu_bus.arvalid = 1;
    #1 chk("t1_latency", m_bus.arvalid, 0);
    @(negedge clock);
    #1 chk("t1_arvalid", m_bus.arvalid, 1);
    chk("t1_araddr", m_bus.araddr, 32'h3000_0000);
    chk("t1_arsize", m_bus.arsize, 3'b010);
    chk("t1_wait_arready", ifu_bus.arready, 0);
    @(negedge clock);
    @(negedge clock); m_bus.arready = 1;
    #1 chk("t1_arready", ifu_bus.arready, 1);
    chk("t1_lsu_arready", lsu_bus.arready, 0);
    @(negedge clock);
    ifu_bus.arvalid = 0; m_bus.arready = 0;
    m_bus.rvalid = 1; m_bus.rdata = 32'h0000_0413; m_bus.rresp = 2'b00; ifu_bus.rready = 1;
    #1 chk("t1_rvalid", ifu_bus.rvalid, 1);
    chk("t1_rdata", ifu_bus.rdata, 32'h0000_0413);
    chk("t1_rresp", ifu_bus.rresp, 0);
    chk("t1_rready", m_bus.rready, 1);
    chk("t1_lsu_rvalid", lsu_bus.rvalid, 0);
    // Stray response in IDLE is not accepted nor forwarded.
    @(negedge clock); m_bus.rdata = 32'hdead_beef;
    #1 chk("t6_stray_rready", m_bus.rready, 0);
    chk("t6_stray_ifu", ifu_bus.rvalid, 0);
    chk("t6_stray_lsu", lsu_bus.rvalid, 0);
    @(negedge clock); clear_inputs();

    // Contention: LSU read wins, IFU follows after one IDLE cycle.
    @(negedge clock);
    ifu_bus.araddr = 32'h3000_0040; ifu_bus.arvalid = 1;
    lsu_bus.araddr = 32'h8000_0010; lsu_bus.arsize = 3'd0; lsu_bus.arvalid = 1;
    #1 chk("t2_latency", m_bus.arvalid, 0);
    @(negedge clock); m_bus.arready = 1;
    #1 chk("t2_lsu_araddr", m_bus.araddr, 32'h8000_0010);
    chk("t2_lsu_arsize", m_bus.arsize, 0);
    chk("t2_lsu_arready", lsu_bus.arready, 1);
    chk("t2_ifu_blocked", ifu_bus.arready, 0);
    @(negedge clock);
    lsu_bus.arvalid = 0; m_bus.arready = 0;
    m_bus.rvalid = 1; m_bus.rdata = 32'hcafe_0001; m_bus.rresp = 2'b10; lsu_bus.rready = 1;
    #1 chk("t2_lsu_rdata", lsu_bus.rdata, 32'hcafe_0001);
    chk("t2_lsu_rresp", lsu_bus.rresp, 2'b10);
    chk("t2_ifu_rvalid", ifu_bus.rvalid, 0);
    @(negedge clock); m_bus.rvalid = 0; lsu_bus.rready = 0;
    #1 chk("t2_gap", m_bus.arvalid, 0);
    @(negedge clock); m_bus.arready = 1;
    #1 chk("t2_ifu_araddr", m_bus.araddr, 32'h3000_0040);
    chk("t2_ifu_arready", ifu_bus.arready, 1);
    @(negedge clock);
    ifu_bus.arvalid = 0; m_bus.arready = 0;
    m_bus.rvalid = 1; m_bus.rdata = 32'h1111_2222; ifu_bus.rready = 1;
    #1 chk("t2_ifu_rdata", ifu_bus.rdata, 32'h1111_2222);
    @(negedge clock); clear_inputs();

    // LSU write, w channel completes three cycles before aw.
    @(negedge clock);
    lsu_bus.awaddr = 32'h8000_0100; lsu_bus.awsize = 3'd2; lsu_bus.awvalid = 1;
    lsu_bus.wdata = 32'h1234_5678; lsu_bus.wstrb = 4'hc; lsu_bus.wvalid = 1;
    #1 chk("t3_latency", m_bus.awvalid, 0);
    @(negedge clock); m_bus.wready = 1;
    #1 chk("t3_awaddr", m_bus.awaddr, 32'h8000_0100);
    chk("t3_wdata", m_bus.wdata, 32'h1234_5678);
    chk("t3_wstrb", m_bus.wstrb, 4'hc);
    chk("t3_wready", lsu_bus.wready, 1);
    chk("t3_awready_early", lsu_bus.awready, 0);
    @(negedge clock); lsu_bus.wvalid = 0; m_bus.wready = 0;
    #1 chk("t3_wvalid_drop", m_bus.wvalid, 0);
    chk("t3_aw_held", m_bus.awvalid, 1);
    repeat (2) @(negedge clock);
    m_bus.awready = 1;
    #1 chk("t3_awready", lsu_bus.awready, 1);
    @(negedge clock);
    lsu_bus.awvalid = 0; m_bus.awready = 0; m_bus.bvalid = 1; m_bus.bresp = 2'b01;
    #1 chk("t3_bvalid", lsu_bus.bvalid, 1);
    chk("t3_bresp", lsu_bus.bresp, 2'b01);
    chk("t3_bready_wait", m_bus.bready, 0);
    @(negedge clock); lsu_bus.bready = 1;
    #1 chk("t3_bready", m_bus.bready, 1);
    @(negedge clock);
    #1 chk("t3_idle_bready", m_bus.bready, 0);
    chk("t3_idle_bvalid", lsu_bus.bvalid, 0);
    @(negedge clock); clear_inputs();

    // LSU read under four cycles of response backpressure.
    @(negedge clock); lsu_bus.araddr = 32'h8000_0020; lsu_bus.arsize = 3'd2; lsu_bus.arvalid = 1;
    @(negedge clock); m_bus.arready = 1;
    #1 chk("t4_arready", lsu_bus.arready, 1);
    @(negedge clock);
    lsu_bus.arvalid = 0; m_bus.arready = 0; m_bus.rvalid = 1; m_bus.rdata = 32'h0bad_f00d;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t4_bp_rready", m_bus.rready, 0);
      chk("t4_bp_rvalid", lsu_bus.rvalid, 1);
      @(negedge clock);
    end
    lsu_bus.rready = 1;
    #1 chk("t4_rready", m_bus.rready, 1);
    chk("t4_rdata", lsu_bus.rdata, 32'h0bad_f00d);
    @(negedge clock);
    #1 chk("t4_once", m_bus.rready, 0);
    chk("t4_once_rvalid", lsu_bus.rvalid, 0);
    @(negedge clock); clear_inputs();

    // Reset in IFU_RD after the ar handshake.
    @(negedge clock); ifu_bus.araddr = 32'h3000_0080; ifu_bus.arvalid = 1;
    @(negedge clock); m_bus.arready = 1;
    #1 chk("t5_arready", ifu_bus.arready, 1);
    @(negedge clock); m_bus.arready = 0;
    #1 chk("t5_in_rd", m_bus.arvalid, 1);
    @(negedge clock); reset = 1'b1; m_bus.rvalid = 1; ifu_bus.rready = 1;
    #1 chk("t5_rst_arvalid", m_bus.arvalid, 0);
    chk("t5_rst_rready", m_bus.rready, 0);
    chk("t5_rst_ifu_rvalid", ifu_bus.rvalid, 0);
    @(negedge clock); clear_inputs(); reset = 1'b0;
    @(negedge clock); lsu_bus.araddr = 32'h8000_0030; lsu_bus.arsize = 3'd1; lsu_bus.arvalid = 1;
    #1 chk("t5_post_latency", m_bus.arvalid, 0);
    @(negedge clock); m_bus.arready = 1;
    #1 chk("t5_post_araddr", m_bus.araddr, 32'h8000_0030);
    chk("t5_post_arsize", m_bus.arsize, 3'd1);
    chk("t5_post_arready", lsu_bus.arready, 1);
    @(negedge clock);
    lsu_bus.arvalid = 0; m_bus.arready = 0; m_bus.rvalid = 1; m_bus.rdata = 32'h7777_0030;
    lsu_bus.rready = 1;
    #1 chk("t5_post_rdata", lsu_bus.rdata, 32'h7777_0030);
    @(negedge clock); clear_inputs();

    // Randomized bundles of simultaneous requests against the transaction model.
    {ifu_p, lrd_p, lwr_p, done, timed_out} = '0;
    {s_rbusy, s_rv, s_awg, s_wg, s_bv} = '0;
    {h_ar, h_iar, h_lar, h_r, h_ir, h_lr, h_aw, h_law, h_w, h_lw, h_b, h_lb} = '0;
    s_ra = '0; s_wa = '0; s_wd = '0; s_ws = '0; s_bresp = '0; s_rdly = 0;
    h_araddr = '0; h_awaddr = '0; h_wdata = '0; h_wstrb = '0;
    ifu_a = '0; lrd_a = '0; lwr_a = '0; lwr_d = '0; lrd_s = '0; lwr_s = '0;
    bundles = 0; bcyc = 0;
    while (!done) begin
      @(negedge clock);
      if (h_ar) begin s_rbusy = 1; s_ra = h_araddr; s_rdly = int'($urandom_range(0, 2)); end
      if (h_iar) ifu_bus.arvalid = 0;
      if (h_lar) lsu_bus.arvalid = 0;
      if (h_r) begin s_rbusy = 0; s_rv = 0; end
      if (h_ir) begin ifu_p = 0; got_q.push_back(0); end
      if (h_lr) begin lrd_p = 0; got_q.push_back(1); end
      if (h_aw) begin s_awg = 1; s_wa = h_awaddr; end
      if (h_law) lsu_bus.awvalid = 0;
      if (h_w) begin s_wg = 1; s_wd = h_wdata; s_ws = h_wstrb; end
      if (h_lw) lsu_bus.wvalid = 0;
      if (h_b) s_bv = 0;
      if (h_lb) begin
        lwr_p = 0; got_q.push_back(2);
        exp_mem[lwr_a] = merge(rd_exp(lwr_a), lwr_d, lwr_s);
      end
      if (s_awg && s_wg) begin
        slv_mem[s_wa] = merge(rd_slv(s_wa), s_wd, s_ws);
        s_bresp = s_wa[5:4]; s_bv = 1; s_awg = 0; s_wg = 0;
      end
      if (s_rbusy && !s_rv) begin
        if (s_rdly == 0) s_rv = 1;
        else s_rdly--;
      end

      if (!ifu_p && !lrd_p && !lwr_p) begin
        if (bundles > 0) begin
          chk("rnd_order_len", got_q.size(), exp_q.size());
          for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("rnd_order", got_q[i], exp_q[i]);
        end
        got_q.delete(); exp_q.delete(); bcyc = 0;
        if (bundles == NUM_BUNDLES) begin
          done = 1;
        end else begin
          bundles++;
          pick = $urandom_range(1, 7);
          if (pick[1]) begin
            lrd_p = 1; exp_q.push_back(1);
            lrd_a = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 2);
            lrd_s = 3'($urandom_range(0, 2));
            lsu_bus.araddr = lrd_a; lsu_bus.arsize = lrd_s; lsu_bus.arvalid = 1;
          end
          if (pick[2]) begin
            lwr_p = 1; exp_q.push_back(2);
            lwr_a = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 2);
            lwr_d = $urandom;
            lwr_s = 4'($urandom_range(1, 15));
            lsu_bus.awaddr = lwr_a; lsu_bus.awsize = 3'd2; lsu_bus.awvalid = 1;
            lsu_bus.wdata = lwr_d; lsu_bus.wstrb = lwr_s; lsu_bus.wvalid = 1;
          end
          if (pick[0]) begin
            ifu_p = 1; exp_q.push_back(0);
            ifu_a = 32'h3000_0000 | (32'($urandom_range(0, 15)) << 2);
            ifu_bus.araddr = ifu_a; ifu_bus.arvalid = 1;
          end
        end
      end
      if (done) break;

      bcyc++;
      if (bcyc > BUNDLE_BUDGET) begin
        chk("rnd_timeout", 1, 0);
        timed_out = 1;
        break;
      end

      m_bus.arready  = 1'($urandom_range(0, 1));
      m_bus.awready  = 1'($urandom_range(0, 1));
      m_bus.wready   = 1'($urandom_range(0, 1));
      m_bus.rvalid   = s_rv;
      m_bus.rdata    = s_rv ? rd_slv(s_ra) : $urandom;
      m_bus.rresp    = s_rv ? s_ra[5:4] : 2'b00;
      m_bus.bvalid   = s_bv;
      m_bus.bresp    = s_bresp;
      ifu_bus.rready = 1'($urandom_range(0, 1));
      lsu_bus.rready = 1'($urandom_range(0, 1));
      lsu_bus.bready = 1'($urandom_range(0, 1));
      #1;

      chk("rnd_excl", m_bus.arvalid && (m_bus.awvalid || m_bus.wvalid), 0);

      h_ar = m_bus.arvalid && m_bus.arready;
      h_iar = ifu_bus.arvalid && ifu_bus.arready;
      h_lar = lsu_bus.arvalid && lsu_bus.arready;
      h_araddr = m_bus.araddr;
      if (h_ar || h_iar || h_lar) begin
        chk("rnd_ar_fwd", {h_ar, h_iar && h_lar}, 2'b10);
        if (h_iar) begin
          chk("rnd_ifu_araddr", m_bus.araddr, ifu_a);
          chk("rnd_ifu_arsize", m_bus.arsize, 3'b010);
        end
        if (h_lar) begin
          chk("rnd_lsu_araddr", m_bus.araddr, lrd_a);
          chk("rnd_lsu_arsize", m_bus.arsize, lrd_s);
        end
      end

      h_r = m_bus.rvalid && m_bus.rready;
      h_ir = ifu_bus.rvalid && ifu_bus.rready;
      h_lr = lsu_bus.rvalid && lsu_bus.rready;
      if (h_r || h_ir || h_lr) begin
        chk("rnd_r_fwd", {h_r, h_ir && h_lr}, 2'b10);
        if (h_ir) begin
          chk("rnd_ifu_rdata", ifu_bus.rdata, rd_exp(ifu_a));
          chk("rnd_ifu_rresp", ifu_bus.rresp, ifu_a[5:4]);
        end
        if (h_lr) begin
          chk("rnd_lsu_rdata", lsu_bus.rdata, rd_exp(lrd_a));
          chk("rnd_lsu_rresp", lsu_bus.rresp, lrd_a[5:4]);
        end
      end

      h_aw = m_bus.awvalid && m_bus.awready;
      h_law = lsu_bus.awvalid && lsu_bus.awready;
      h_awaddr = m_bus.awaddr;
      if (h_aw || h_law) begin
        chk("rnd_aw_fwd", {h_aw, h_law}, 2'b11);
        chk("rnd_awaddr", m_bus.awaddr, lwr_a);
      end

      h_w = m_bus.wvalid && m_bus.wready;
      h_lw = lsu_bus.wvalid && lsu_bus.wready;
      h_wdata = m_bus.wdata;
      h_wstrb = m_bus.wstrb;
      if (h_w || h_lw) begin
        chk("rnd_w_fwd", {h_w, h_lw}, 2'b11);
        chk("rnd_wdata", m_bus.wdata, lwr_d);
        chk("rnd_wstrb", m_bus.wstrb, lwr_s);
      end

      h_b = m_bus.bvalid && m_bus.bready;
      h_lb = lsu_bus.bvalid && lsu_bus.bready;
      if (h_b || h_lb) begin
        chk("rnd_b_fwd", {h_b, h_lb}, 2'b11);
        chk("rnd_bresp", lsu_bus.bresp, lwr_a[5:4]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
